// File: rtl/epp_reg_bank.sv
// epp_reg_bank: register bank and byte-stream bridge behind the EPP port block.
// Host transfers are tracked through the port block's WAIT (EPP_BUSY) signal
// and committed once, on the cycle busy falls. Eight control registers are
// exported on CTRL. A status register and two byte FIFOs (OUT: host->fabric,
// IN: fabric->host) give software a simple streaming path into user logic.
module epp_reg_bank #(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EPP_BUSY,
    input  logic [7:0]  EPP_ADDR,
    input  logic [7:0]  EPP_DATA,
    input  logic        nDSTB,
    input  logic        nWRITE,
    output logic [7:0]  DATA_TX,
    output logic [63:0] CTRL,
    output logic [7:0]  OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY
);

    localparam int unsigned      DEPTH       = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LVL_FULL    = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [7:0]       ADDR_STATUS = 8'h08;
    localparam logic [7:0]       ADDR_DATA   = 8'h09;
    localparam logic [7:0]       ADDR_OUT_LV = 8'h0A;
    localparam logic [7:0]       ADDR_IN_LV  = 8'h0B;

    // transaction tracking
    logic busy_q, busy_d;
    logic wp_q, wp_d;
    logic rp_q, rp_d;
    logic commit;
    logic host_wr;
    logic host_rd;

    // register file and sticky status
    logic [7:0] reg_q [8];
    logic [7:0] reg_d [8];
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic       ovf_set, ovf_clr;
    logic       unf_set, unf_clr;

    // OUT FIFO (host -> fabric)
    logic [7:0]         out_mem_q [DEPTH];
    logic [FIFO_AW-1:0] out_wr_ptr_q, out_wr_ptr_d;
    logic [FIFO_AW-1:0] out_rd_ptr_q, out_rd_ptr_d;
    logic [FIFO_AW:0]   out_lvl_q, out_lvl_d;
    logic               out_full, out_empty;
    logic               out_push, out_pop;

    // IN FIFO (fabric -> host)
    logic [7:0]         in_mem_q [DEPTH];
    logic [FIFO_AW-1:0] in_wr_ptr_q, in_wr_ptr_d;
    logic [FIFO_AW-1:0] in_rd_ptr_q, in_rd_ptr_d;
    logic [FIFO_AW:0]   in_lvl_q, in_lvl_d;
    logic               in_full, in_empty;
    logic               in_push, in_pop;

    // Pending-flag tracking: data strobes arm WP/RP, busy falling commits once.
    always_comb begin
        busy_d = EPP_BUSY;
        commit = busy_q && !EPP_BUSY;
        wp_d   = wp_q;
        rp_d   = rp_q;
        if (commit) begin
            wp_d = 1'b0;
            rp_d = 1'b0;
        end else if (EPP_BUSY && !nDSTB) begin
            if (nWRITE) begin
                rp_d = 1'b1;
            end else begin
                wp_d = 1'b1;
            end
        end
        host_wr = commit && wp_q;
        host_rd = commit && rp_q;
    end

    // Control register writes from committed host data writes.
    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            reg_d[i] = reg_q[i];
        end
        if (host_wr && (EPP_ADDR[7:3] == 5'd0)) begin
            reg_d[EPP_ADDR[2:0]] = EPP_DATA;
        end
    end

    // FIFO handshakes; a full OUT FIFO drops host bytes even if the fabric pops.
    always_comb begin
        out_full  = (out_lvl_q == LVL_FULL);
        out_empty = (out_lvl_q == '0);
        in_full   = (in_lvl_q == LVL_FULL);
        in_empty  = (in_lvl_q == '0);

        out_push  = host_wr && (EPP_ADDR == ADDR_DATA) && !out_full;
        out_pop   = !out_empty && OUT_READY;
        in_push   = IN_VALID && !in_full;
        in_pop    = host_rd && (EPP_ADDR == ADDR_DATA) && !in_empty;

        OUT_VALID = !out_empty;
        OUT_DATA  = out_mem_q[out_rd_ptr_q];
        IN_READY  = !in_full;
    end

    // OUT FIFO pointer and level bookkeeping.
    always_comb begin
        out_wr_ptr_d = out_wr_ptr_q;
        out_rd_ptr_d = out_rd_ptr_q;
        out_lvl_d    = out_lvl_q;
        if (out_push) begin
            out_wr_ptr_d = out_wr_ptr_q + 1'b1;
        end
        if (out_pop) begin
            out_rd_ptr_d = out_rd_ptr_q + 1'b1;
        end
        case ({out_push, out_pop})
            2'b10:   out_lvl_d = out_lvl_q + 1'b1;
            2'b01:   out_lvl_d = out_lvl_q - 1'b1;
            default: out_lvl_d = out_lvl_q;
        endcase
    end

    // IN FIFO pointer and level bookkeeping.
    always_comb begin
        in_wr_ptr_d = in_wr_ptr_q;
        in_rd_ptr_d = in_rd_ptr_q;
        in_lvl_d    = in_lvl_q;
        if (in_push) begin
            in_wr_ptr_d = in_wr_ptr_q + 1'b1;
        end
        if (in_pop) begin
            in_rd_ptr_d = in_rd_ptr_q + 1'b1;
        end
        case ({in_push, in_pop})
            2'b10:   in_lvl_d = in_lvl_q + 1'b1;
            2'b01:   in_lvl_d = in_lvl_q - 1'b1;
            default: in_lvl_d = in_lvl_q;
        endcase
    end

    // Sticky overflow/underflow flags: write-1-to-clear, a same-cycle set wins.
    always_comb begin
        ovf_set = host_wr && (EPP_ADDR == ADDR_DATA) && out_full;
        unf_set = host_rd && (EPP_ADDR == ADDR_DATA) && in_empty;
        ovf_clr = host_wr && (EPP_ADDR == ADDR_STATUS) && EPP_DATA[2];
        unf_clr = host_wr && (EPP_ADDR == ADDR_STATUS) && EPP_DATA[3];

        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end

        unf_d = unf_q;
        if (unf_clr) begin
            unf_d = 1'b0;
        end
        if (unf_set) begin
            unf_d = 1'b1;
        end
    end

    // Host read-data mux, purely a function of the latched address.
    always_comb begin
        DATA_TX = 8'h00;
        if (EPP_ADDR[7:3] == 5'd0) begin
            DATA_TX = reg_q[EPP_ADDR[2:0]];
        end else begin
            case (EPP_ADDR)
                ADDR_STATUS: DATA_TX = {4'b0000, unf_q, ovf_q, out_full, in_empty};
                ADDR_DATA:   DATA_TX = in_empty ? 8'h00 : in_mem_q[in_rd_ptr_q];
                ADDR_OUT_LV: DATA_TX = 8'(out_lvl_q);
                ADDR_IN_LV:  DATA_TX = 8'(in_lvl_q);
                default:     DATA_TX = 8'h00;
            endcase
        end
    end

    // Control registers flattened onto CTRL, REG0 in the low byte.
    always_comb begin
        CTRL = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            CTRL[i*8 +: 8] = reg_q[i];
        end
    end

    // State flops with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy_q       <= 1'b0;
            wp_q         <= 1'b0;
            rp_q         <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            out_lvl_q    <= '0;
            in_wr_ptr_q  <= '0;
            in_rd_ptr_q  <= '0;
            in_lvl_q     <= '0;
            for (int unsigned i = 0; i < 8; i++) begin
                reg_q[i] <= '0;
            end
        end else begin
            busy_q       <= busy_d;
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            out_lvl_q    <= out_lvl_d;
            in_wr_ptr_q  <= in_wr_ptr_d;
            in_rd_ptr_q  <= in_rd_ptr_d;
            in_lvl_q     <= in_lvl_d;
            for (int unsigned i = 0; i < 8; i++) begin
                reg_q[i] <= reg_d[i];
            end
        end
    end

    // FIFO storage; contents need no reset since levels gate visibility.
    always_ff @(posedge CLK) begin
        if (out_push) begin
            out_mem_q[out_wr_ptr_q] <= EPP_DATA;
        end
        if (in_push) begin
            in_mem_q[in_wr_ptr_q] <= IN_DATA;
        end
    end

endmodule

// File: tb/tb_epp_reg_bank.sv
// Testbench for epp_reg_bank: directed scenarios plus randomized host
// transfers and fabric traffic, checked against a queue-based model.
module tb_epp_reg_bank;

    localparam int unsigned AW    = 4;
    localparam int          DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EPP_BUSY = 1'b0;
    logic [7:0]  EPP_ADDR = 8'h00;
    logic [7:0]  EPP_DATA = 8'h00;
    logic        nDSTB = 1'b1;
    logic        nWRITE = 1'b1;
    logic [7:0]  DATA_TX;
    logic [63:0] CTRL;
    logic [7:0]  OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [7:0]  IN_DATA = 8'h00;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;

    epp_reg_bank #(.FIFO_AW(AW)) dut (
        .CLK(CLK), .RST(RST), .EPP_BUSY(EPP_BUSY), .EPP_ADDR(EPP_ADDR),
        .EPP_DATA(EPP_DATA), .nDSTB(nDSTB), .nWRITE(nWRITE), .DATA_TX(DATA_TX),
        .CTRL(CTRL), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY)
    );

    always #5 CLK = ~CLK;

    // reference model
    logic [7:0] m_reg [8];
    logic       m_ovf, m_unf;
    logic [7:0] outq [$];
    logic [7:0] inq [$];
    bit         host_commit = 1'b0;
    bit         host_is_wr  = 1'b0;
    bit         rand_fabric = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        if (a < 8'h08)  return m_reg[a[2:0]];
        if (a == 8'h08) return {4'b0000, m_unf, m_ovf, outq.size() == DEPTH, inq.size() == 0};
        if (a == 8'h09) return (inq.size() > 0) ? inq[0] : 8'h00;
        if (a == 8'h0A) return 8'(outq.size());
        if (a == 8'h0B) return 8'(inq.size());
        return 8'h00;
    endfunction

    function automatic logic [63:0] model_ctrl();
        logic [63:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c[i*8 +: 8] = m_reg[i];
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        outq.delete();
        inq.delete();
    endtask

    // Applies one clock cycle of host commit and fabric traffic to the model.
    task automatic model_step();
        bit out_pop, in_push, h_push, h_pop;
        if (RST) return;
        out_pop = (outq.size() > 0) && OUT_READY;
        in_push = IN_VALID && (inq.size() < DEPTH);
        h_push  = 1'b0;
        h_pop   = 1'b0;
        if (host_commit) begin
            if (host_is_wr) begin
                if (EPP_ADDR < 8'h08) m_reg[EPP_ADDR[2:0]] = EPP_DATA;
                else if (EPP_ADDR == 8'h08) begin
                    if (EPP_DATA[2]) m_ovf = 1'b0;
                    if (EPP_DATA[3]) m_unf = 1'b0;
                end else if (EPP_ADDR == 8'h09) begin
                    if (outq.size() == DEPTH) m_ovf = 1'b1;
                    else h_push = 1'b1;
                end
            end else if (EPP_ADDR == 8'h09) begin
                if (inq.size() == 0) m_unf = 1'b1;
                else h_pop = 1'b1;
            end
        end
        if (out_pop) void'(outq.pop_front());
        if (h_push)  outq.push_back(EPP_DATA);
        if (h_pop)   void'(inq.pop_front());
        if (in_push) inq.push_back(IN_DATA);
    endtask

    task automatic check_all();
        check("ctrl", CTRL, model_ctrl());
        check("out_valid", 64'(OUT_VALID), 64'(outq.size() > 0));
        if (outq.size() > 0) check("out_data", 64'(OUT_DATA), 64'(outq[0]));
        check("in_ready", 64'(IN_READY), 64'(inq.size() < DEPTH));
        check("data_tx", 64'(DATA_TX), 64'(model_rd(EPP_ADDR)));
    endtask

    task automatic tick();
        if (rand_fabric) begin
            IN_VALID  = 1'($urandom_range(0, 1));
            IN_DATA   = 8'($urandom);
            OUT_READY = ($urandom_range(0, 3) != 0);
        end
        model_step();
        @(posedge CLK);
        @(negedge CLK);
        check_all();
    endtask

    // One EPP transfer: busy high for blen cycles, data strobe from the second
    // busy cycle when strobe is set, then busy falls and the commit cycle runs.
    task automatic transfer(input logic [7:0] a, input logic [7:0] d, input bit wr,
                            input bit strobe, input int blen, input bit rdy_at_commit);
        EPP_ADDR = a;
        EPP_DATA = d;
        nWRITE   = !wr;
        EPP_BUSY = 1'b1;
        nDSTB    = 1'b1;
        tick();
        for (int i = 1; i < blen; i++) begin
            nDSTB = !strobe;
            tick();
        end
        EPP_BUSY    = 1'b0;
        nDSTB       = 1'b1;
        host_commit = strobe;
        host_is_wr  = wr;
        if (rdy_at_commit) OUT_READY = 1'b1;
        tick();
        host_commit = 1'b0;
        if (rdy_at_commit) OUT_READY = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge CLK);
        check_all();
        check("rst_ctrl", CTRL, 64'h0);
        check("rst_in_ready", 64'(IN_READY), 64'h1);
        check("rst_out_valid", 64'(OUT_VALID), 64'h0);
        RST = 1'b0;
        tick();

        // host register write and read-back
        transfer(8'h03, 8'hA5, 1'b1, 1'b1, 4, 1'b0);
        check("t1_ctrl", CTRL, 64'h00000000_A5000000);
        check("t1_rd3", 64'(DATA_TX), 64'hA5);

        // address-only transfer commits nothing
        transfer(8'h05, 8'h5A, 1'b1, 1'b0, 3, 1'b0);
        check("t2_ctrl", CTRL, 64'h00000000_A5000000);
        check("t2_rd5", 64'(DATA_TX), 64'h00);

        // OUT FIFO fill then drain in order
        transfer(8'h09, 8'h11, 1'b1, 1'b1, 3, 1'b0);
        transfer(8'h09, 8'h22, 1'b1, 1'b1, 3, 1'b0);
        transfer(8'h09, 8'h33, 1'b1, 1'b1, 3, 1'b0);
        EPP_ADDR = 8'h0A;
        #1;
        check("t3_lvl", 64'(DATA_TX), 64'h03);
        check("t3_h0", 64'(OUT_DATA), 64'h11);
        OUT_READY = 1'b1;
        tick();
        check("t3_h1", 64'(OUT_DATA), 64'h22);
        tick();
        check("t3_h2", 64'(OUT_DATA), 64'h33);
        tick();
        check("t3_empty", 64'(OUT_VALID), 64'h0);
        OUT_READY = 1'b0;

        // IN FIFO fill, host drain, underflow and W1C
        for (int i = 0; i < DEPTH; i++) begin
            IN_VALID = 1'b1;
            IN_DATA  = 8'(8'h40 + i);
            tick();
        end
        IN_VALID = 1'b0;
        check("t4_in_full", 64'(IN_READY), 64'h0);
        EPP_ADDR = 8'h0B;
        #1;
        check("t4_in_lvl", 64'(DATA_TX), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            EPP_ADDR = 8'h09;
            #1;
            check("t4_in_byte", 64'(DATA_TX), 64'(8'(8'h40 + i)));
            transfer(8'h09, 8'h00, 1'b0, 1'b1, 3, 1'b0);
        end
        EPP_ADDR = 8'h08;
        #1;
        check("t4_stat_empty", 64'(DATA_TX), 64'h01);
        EPP_ADDR = 8'h09;
        #1;
        check("t4_rd_empty", 64'(DATA_TX), 64'h00);
        transfer(8'h09, 8'h00, 1'b0, 1'b1, 3, 1'b0);
        EPP_ADDR = 8'h08;
        #1;
        check("t4_stat_unf", 64'(DATA_TX), 64'h09);
        transfer(8'h08, 8'h08, 1'b1, 1'b1, 3, 1'b0);
        check("t4_stat_clr", 64'(DATA_TX), 64'h01);

        // OUT overflow with a same-cycle fabric pop
        for (int i = 0; i < DEPTH; i++) begin
            transfer(8'h09, 8'(8'h80 + i), 1'b1, 1'b1, 2, 1'b0);
        end
        EPP_ADDR = 8'h0A;
        #1;
        check("t5_full_lvl", 64'(DATA_TX), 64'(DEPTH));
        transfer(8'h09, 8'hEE, 1'b1, 1'b1, 3, 1'b1);
        EPP_ADDR = 8'h0A;
        #1;
        check("t5_lvl", 64'(DATA_TX), 64'(DEPTH - 1));
        EPP_ADDR = 8'h08;
        #1;
        check("t5_stat_ovf", 64'(DATA_TX), 64'h05);
        check("t5_head", 64'(OUT_DATA), 64'h81);
        OUT_READY = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        OUT_READY = 1'b0;
        transfer(8'h08, 8'h04, 1'b1, 1'b1, 2, 1'b0);
        check("t5_stat_clr", 64'(DATA_TX), 64'h01);

        // reset in the middle of a data write
        EPP_ADDR = 8'h01;
        EPP_DATA = 8'h77;
        nWRITE   = 1'b0;
        EPP_BUSY = 1'b1;
        nDSTB    = 1'b1;
        tick();
        nDSTB = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        model_reset();
        #1;
        check_all();
        check("t6_rst_ctrl", CTRL, 64'h0);
        tick();
        RST   = 1'b0;
        nDSTB = 1'b1;
        tick();
        EPP_BUSY = 1'b0;
        tick();
        tick();
        check("t6_reg1", 64'(CTRL[15:8]), 64'h00);
        check("t6_ctrl", CTRL, 64'h0);
        check("t6_in_ready", 64'(IN_READY), 64'h1);
        check("t6_out_valid", 64'(OUT_VALID), 64'h0);

        // randomized host transfers against random fabric traffic
        rand_fabric = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [7:0] a;
            a = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) a = 8'h09;
            if ($urandom_range(0, 19) == 0) a = 8'($urandom);
            transfer(a, 8'($urandom), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 4) != 0), int'($urandom_range(2, 5)), 1'b0);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
        end
        rand_fabric = 1'b0;
        IN_VALID    = 1'b0;
        OUT_READY   = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
